// File: rtl/rgb444_to_gray_engine.sv
// RGB444 -> 8-bit luma streaming stage: reads the colour BRAM in address order and
// writes Y = (77R + 150G + 29B + 128) >> 8 to the same address of the gray BRAM.
module rgb444_to_gray_engine #(
   parameter int PIXELS = 76800,
   parameter int ADDR_W = 17,
   parameter int RD_LAT = 1
) (
   input  logic              i_CLK,
   input  logic              i_RSTn,
   input  logic              i_START,
   output logic              o_COLOR_RDEN,
   output logic [ADDR_W-1:0] o_COLOR_RDADDR,
   input  logic [11:0]       i_COLOR_RDDATA,
   output logic              o_GRAY_WREN,
   output logic [ADDR_W-1:0] o_GRAY_WRADDR,
   output logic [7:0]        o_GRAY_WRDATA,
   output logic              o_BUSY,
   output logic              o_DONE,
   output logic [1:0]        o_DBG_STATE
);

   // Handshake: i_START is a one-cycle request honoured only in IDLE/DONE. The BRAM
   // ports have no backpressure; a read issued in cycle n returns data RD_LAT cycles later.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   state_t            state;
   logic [RD_LAT-1:0] vld_sr;
   logic [ADDR_W-1:0] adr_sr [RD_LAT];
   logic [7:0]        r8;
   logic [7:0]        g8;
   logic [7:0]        b8;
   logic [7:0]        luma;
   logic [16:0]       luma_sum;

   always_comb begin
      r8       = {i_COLOR_RDDATA[11:8], i_COLOR_RDDATA[11:8]};
      g8       = {i_COLOR_RDDATA[7:4],  i_COLOR_RDDATA[7:4]};
      b8       = {i_COLOR_RDDATA[3:0],  i_COLOR_RDDATA[3:0]};
      luma_sum = 17'd77 * {9'd0, r8} + 17'd150 * {9'd0, g8}
               + 17'd29 * {9'd0, b8} + 17'd128;
      luma     = 8'(luma_sum >> 8);
   end

   // The cycle after an accepted start is spent in RUN with reads still off, so the
   // first read, the address restart and the clearing of done all land together.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state          <= S_IDLE;
         o_COLOR_RDEN   <= 1'b0;
         o_COLOR_RDADDR <= '0;
         o_DONE         <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (i_START) state <= S_RUN;
            end
            S_RUN: begin
               if (!o_COLOR_RDEN) begin
                  o_COLOR_RDEN   <= 1'b1;
                  o_COLOR_RDADDR <= '0;
                  o_DONE         <= 1'b0;
               end else if (o_COLOR_RDADDR == LAST_ADDR) begin
                  o_COLOR_RDEN <= 1'b0;
                  state        <= S_DRAIN;
               end else begin
                  o_COLOR_RDADDR <= o_COLOR_RDADDR + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (o_GRAY_WREN && !(|vld_sr)) begin
                  state  <= S_DONE;
                  o_DONE <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read enable/address ride alongside the BRAM latency; the output register is the
   // final stage, which makes the whole valid pipeline RD_LAT+1 deep.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         vld_sr <= '0;
         for (int i = 0; i < RD_LAT; i++) adr_sr[i] <= '0;
         o_GRAY_WREN   <= 1'b0;
         o_GRAY_WRADDR <= '0;
         o_GRAY_WRDATA <= '0;
      end else begin
         vld_sr[0] <= o_COLOR_RDEN;
         adr_sr[0] <= o_COLOR_RDADDR;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            adr_sr[i] <= adr_sr[i-1];
         end
         o_GRAY_WREN <= vld_sr[RD_LAT-1];
         if (vld_sr[RD_LAT-1]) begin
            o_GRAY_WRADDR <= adr_sr[RD_LAT-1];
            o_GRAY_WRDATA <= luma;
         end
      end
   end

   assign o_BUSY      = o_COLOR_RDEN | (|vld_sr) | o_GRAY_WREN;
   assign o_DBG_STATE = state;

endmodule

// File: tb/tb_rgb444_to_gray_engine.sv
// Bench for rgb444_to_gray_engine: three instances (8 px/RD_LAT 1, full frame,
// 1200 px/RD_LAT 3) with BRAM models and per-instance write scoreboards.
module tb_rgb444_to_gray_engine;

   localparam int PA = 8;
   localparam int PB = 76800;
   localparam int PC = 1200;
   localparam int AWA = 3;
   localparam int AWB = 17;
   localparam int AWC = 11;
   localparam int W = 25;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_a, rst_n_b, rst_n_c;
   logic start_a, start_b, start_c;

   logic           rden_a, wren_a, busy_a, done_a;
   logic [AWA-1:0] rdaddr_a, wraddr_a;
   logic [11:0]    rddata_a;
   logic [7:0]     wrdata_a;
   logic [1:0]     st_a;

   logic           rden_b, wren_b, busy_b, done_b;
   logic [AWB-1:0] rdaddr_b, wraddr_b;
   logic [11:0]    rddata_b;
   logic [7:0]     wrdata_b;
   logic [1:0]     st_b;

   logic           rden_c, wren_c, busy_c, done_c;
   logic [AWC-1:0] rdaddr_c, wraddr_c;
   logic [11:0]    rddata_c;
   logic [7:0]     wrdata_c;
   logic [1:0]     st_c;

   rgb444_to_gray_engine #(.PIXELS(PA), .ADDR_W(AWA), .RD_LAT(1)) dut_a (
      .i_CLK(clk), .i_RSTn(rst_n_a), .i_START(start_a),
      .o_COLOR_RDEN(rden_a), .o_COLOR_RDADDR(rdaddr_a), .i_COLOR_RDDATA(rddata_a),
      .o_GRAY_WREN(wren_a), .o_GRAY_WRADDR(wraddr_a), .o_GRAY_WRDATA(wrdata_a),
      .o_BUSY(busy_a), .o_DONE(done_a), .o_DBG_STATE(st_a));

   rgb444_to_gray_engine #(.PIXELS(PB), .ADDR_W(AWB), .RD_LAT(1)) dut_b (
      .i_CLK(clk), .i_RSTn(rst_n_b), .i_START(start_b),
      .o_COLOR_RDEN(rden_b), .o_COLOR_RDADDR(rdaddr_b), .i_COLOR_RDDATA(rddata_b),
      .o_GRAY_WREN(wren_b), .o_GRAY_WRADDR(wraddr_b), .o_GRAY_WRDATA(wrdata_b),
      .o_BUSY(busy_b), .o_DONE(done_b), .o_DBG_STATE(st_b));

   rgb444_to_gray_engine #(.PIXELS(PC), .ADDR_W(AWC), .RD_LAT(3)) dut_c (
      .i_CLK(clk), .i_RSTn(rst_n_c), .i_START(start_c),
      .o_COLOR_RDEN(rden_c), .o_COLOR_RDADDR(rdaddr_c), .i_COLOR_RDDATA(rddata_c),
      .o_GRAY_WREN(wren_c), .o_GRAY_WRADDR(wraddr_c), .o_GRAY_WRDATA(wrdata_c),
      .o_BUSY(busy_c), .o_DONE(done_c), .o_DBG_STATE(st_c));

   // ---------------- colour BRAM models ----------------
   logic [11:0] mem_a [PA];
   logic [11:0] mem_b [PB];
   logic [11:0] mem_c [PC];
   logic [11:0] c_d0, c_d1;

   always @(posedge clk) if (rden_a) rddata_a <= mem_a[rdaddr_a];
   always @(posedge clk) if (rden_b) rddata_b <= mem_b[rdaddr_b];
   always @(posedge clk) begin
      if (rden_c) c_d0 <= mem_c[rdaddr_c];
      c_d1     <= c_d0;
      rddata_c <= c_d1;
   end

   // ---------------- scoreboard ----------------
   int n_chk = 0;
   int n_fail = 0;
   int wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;
   logic [W-1:0] exp_q_a[$];
   logic [W-1:0] exp_q_b[$];
   logic [W-1:0] exp_q_c[$];

   typedef struct {
      logic [11:0] pix;
      logic [7:0]  gray;
   } vec_t;
   vec_t vec [8];

   function automatic int ref_gray(input logic [11:0] p);
      int r, g, b;
      r = int'(p[11:8]) * 17;
      g = int'(p[7:4]) * 17;
      b = int'(p[3:0]) * 17;
      return (77 * r + 150 * g + 29 * b + 128) / 256;
   endfunction

   function automatic logic [W-1:0] pk(input int addr, input int gray);
      return W'(addr * 256 + gray);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic extra_write(input string name, input int addr);
      n_chk++;
      n_fail++;
      $display("FAIL %s: write to addr %0d with nothing expected", name, addr);
   endtask

   always @(negedge clk) if (wren_a) begin
      wcnt_a++;
      if (exp_q_a.size() == 0) extra_write("a_extra_write", int'(wraddr_a));
      else check("a_write", pk(int'(wraddr_a), int'(wrdata_a)), exp_q_a.pop_front());
   end

   always @(negedge clk) if (wren_b) begin
      wcnt_b++;
      if (exp_q_b.size() == 0) extra_write("b_extra_write", int'(wraddr_b));
      else check("b_write", pk(int'(wraddr_b), int'(wrdata_b)), exp_q_b.pop_front());
   end

   always @(negedge clk) if (wren_c) begin
      wcnt_c++;
      if (exp_q_c.size() == 0) extra_write("c_extra_write", int'(wraddr_c));
      else check("c_write", pk(int'(wraddr_c), int'(wrdata_c)), exp_q_c.pop_front());
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge inside cycle 0.
   task automatic pulse_start(input int sel);
      case (sel)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   function automatic logic get_done(input int sel);
      case (sel)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic wait_done(input int sel, input int budget, output int cyc);
      cyc = 0;
      while (!get_done(sel) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!get_done(sel)) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: instance %0d no done within %0d cycles", sel, budget);
      end
   endtask

   // Per-cycle control check of instance A; x1/x2 are cycles whose end samples an extra start.
   task automatic run_a_frame(input int x1, input int x2, input logic done0);
      logic [7:0] exp_v, got_v;
      pulse_start(0);
      for (int n = 0; n < 14; n++) begin
         if (n > 0) @(negedge clk);
         got_v = {rden_a, wren_a, busy_a, done_a, rden_a ? {1'b0, rdaddr_a} : 4'd0};
         exp_v = {(n >= 1 && n <= 8), (n >= 3 && n <= 10), (n >= 1 && n <= 10),
                  (n == 0) ? done0 : (n >= 11),
                  (n >= 1 && n <= 8) ? 4'(n - 1) : 4'd0};
         check($sformatf("a_cycle%0d", n), got_v, exp_v);
         start_a = (n == x1 || n == x2);
      end
      start_a = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc;
      vec[0] = '{12'h000, 8'd0};
      vec[1] = '{12'hFFF, 8'd255};
      vec[2] = '{12'hF00, 8'd77};
      vec[3] = '{12'h0F0, 8'd149};
      vec[4] = '{12'h00F, 8'd29};
      vec[5] = '{12'h888, 8'd136};
      vec[6] = '{12'h123, 8'd31};
      vec[7] = '{12'hABC, 8'd184};  // (170*77 + 187*150 + 204*29 + 128) >> 8

      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a", {rden_a, rdaddr_a, wren_a, wraddr_a, wrdata_a, busy_a, done_a, st_a}, 0);
      check("rst_b", {rden_b, rdaddr_b, wren_b, wraddr_b, wrdata_b, busy_b, done_b, st_b}, 0);
      check("rst_c", {rden_c, rdaddr_c, wren_c, wraddr_c, wrdata_c, busy_c, done_c, st_c}, 0);
      rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_activity", {rden_a | rden_b | rden_c, wren_a | wren_b | wren_c,
                                 done_a | done_b | done_c}, 0);
      end

      // Corner pixels on instance A with the exact cycle profile.
      for (int i = 0; i < PA; i++) begin
         mem_a[i] = vec[i].pix;
         exp_q_a.push_back(pk(i, int'(vec[i].gray)));
      end
      wcnt_a = 0;
      run_a_frame(-1, -1, 1'b0);
      check("a_q_empty", exp_q_a.size(), 0);
      check("a_wcnt", wcnt_a, PA);

      // Restart from DONE with extra starts in RUN (sampled E4) and DRAIN (sampled E10).
      for (int i = 0; i < PA; i++) exp_q_a.push_back(pk(i, int'(vec[i].gray)));
      wcnt_a = 0;
      run_a_frame(3, 9, 1'b1);
      check("a2_q_empty", exp_q_a.size(), 0);
      check("a2_wcnt", wcnt_a, PA);
      check("a2_state_done", st_a, 2'd3);

      // Instance C (RD_LAT=3): reset when read address 1000 is on the bus.
      for (int i = 0; i < PC; i++) begin
         mem_c[i] = 12'($urandom_range(0, 4095));
         exp_q_c.push_back(pk(i, ref_gray(mem_c[i])));
      end
      wcnt_c = 0;
      pulse_start(2);
      cyc = 0;
      while (!(rden_c && rdaddr_c == AWC'(1000)) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("c_reach_1000", {rden_c, rdaddr_c}, {1'b1, AWC'(1000)});
      #1;
      check("c_wcnt_before_rst", wcnt_c, 997);
      rst_n_c = 1'b0;
      #1;
      check("c_async_rst", {rden_c, rdaddr_c, wren_c, wraddr_c, wrdata_c, busy_c, done_c, st_c}, 0);
      exp_q_c.delete();
      repeat (6) @(negedge clk);
      check("c_held_rst", {rden_c, wren_c, busy_c, done_c}, 0);
      rst_n_c = 1'b1;
      repeat (4) @(negedge clk);
      check("c_post_rst_idle", {rden_c, wren_c, busy_c, done_c, st_c}, 0);
      for (int i = 0; i < PC; i++) exp_q_c.push_back(pk(i, ref_gray(mem_c[i])));
      wcnt_c = 0;
      pulse_start(2);
      wait_done(2, 1500, cyc);
      check("c_done_cycle", cyc, PC + 3 + 2);
      check("c_wcnt", wcnt_c, PC);
      check("c_q_empty", exp_q_c.size(), 0);

      // Instance B: full random frame.
      for (int i = 0; i < PB; i++) begin
         mem_b[i] = 12'($urandom_range(0, 4095));
         exp_q_b.push_back(pk(i, ref_gray(mem_b[i])));
      end
      wcnt_b = 0;
      pulse_start(1);
      wait_done(1, PB + 100, cyc);
      check("b_done_cycle", cyc, PB + 1 + 2);
      check("b_wcnt", wcnt_b, PB);
      check("b_q_empty", exp_q_b.size(), 0);
      repeat (3) @(negedge clk);
      check("b_done_sticky", {done_b, busy_b, wren_b}, 3'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
